// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD run controller.
// State encoding, host operand address and default timeouts.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    START,
    ACK,
    RUN,
    FAIL,
    DONE
  } state_t;

  localparam int HADDR_OPS        = 0;
  localparam int DEF_DEBOUNCE_CYC = 16;
  localparam int DEF_SETTLE_CYC   = 2;
  localparam int DEF_ACK_TO       = 16;
  localparam int DEF_RUN_TO       = 1000000;

endpackage

// File: rtl/op_debounce.sv
// Switch operand synchroniser and stability filter.
// Pulses accept once per newly stable operand pair.
module op_debounce
  import gcd_pkg::*;
#(
  parameter int OP_W         = 8,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  output logic            accept,
  output logic [OP_W-1:0] pair_a,
  output logic [OP_W-1:0] pair_b
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] CMAX = DW'(DEBOUNCE_CYC - 1);

  logic [OP_W-1:0] sa1, sa2, sb1, sb2;
  logic [OP_W-1:0] pa, pb;
  logic [OP_W-1:0] la, lb;
  logic            lvld;
  logic [DW-1:0]   cnt;
  logic            moved;

  assign moved  = (sa2 != pa) || (sb2 != pb);
  assign pair_a = pa;
  assign pair_b = pb;
  // lvld low after reset so the first stable pair always differs
  assign accept = (cnt == CMAX)
                && (!lvld || pa != la || pb != lb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa1  <= '0;
      sa2  <= '0;
      sb1  <= '0;
      sb2  <= '0;
      pa   <= '0;
      pb   <= '0;
      la   <= '0;
      lb   <= '0;
      lvld <= 1'b0;
      cnt  <= '0;
    end else begin
      sa1 <= op_a;
      sa2 <= sa1;
      sb1 <= op_b;
      sb2 <= sb1;
      pa  <= sa2;
      pb  <= sb2;
      if (moved)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
      if (accept) begin
        la   <= pa;
        lb   <= pb;
        lvld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_run_ctrl.sv
// Sequencer that loads switch operands into the GCD CPU,
// starts it, supervises the busy handshake and keeps the result.
module gcd_run_ctrl
  import gcd_pkg::*;
#(
  parameter int OP_W         = 8,
  parameter int DATA_W       = 32,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int ACK_TO       = DEF_ACK_TO,
  parameter int RUN_TO       = DEF_RUN_TO,
  parameter int CNT_W        = 24
) (
  input  logic              CLK_1M,
  input  logic              rst,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  input  logic              cpu_bsy,
  input  logic [DATA_W-1:0] cpu_gcd,
  output logic              cpu_wen,
  output logic [DATA_W-1:0] cpu_haddr,
  output logic [DATA_W-1:0] cpu_hdin1,
  output logic [DATA_W-1:0] cpu_hdin2,
  output logic              cpu_start,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TO - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TO - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept;
  logic [OP_W-1:0]  db_a, db_b;
  logic             pending;
  logic [OP_W-1:0]  pend_a, pend_b;
  logic             launch;
  logic [OP_W-1:0]  la, lb;
  logic             zero_op;

  op_debounce #(
    .OP_W        (OP_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db (
    .clk   (CLK_1M),
    .rst   (rst),
    .op_a  (op_a),
    .op_b  (op_b),
    .accept(accept),
    .pair_a(db_a),
    .pair_b(db_b)
  );

  assign zero_op = (la == '0) || (lb == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    launch  = 1'b0;
    la      = db_a;
    lb      = db_b;
    unique case (state)
      IDLE:   launch = accept;
      LOAD: begin
        state_n = SETTLE;
        cnt_n   = '0;
      end
      SETTLE: begin
        if (cnt == SET_LAST) state_n = START;
        else cnt_n = cnt + 1'b1;
      end
      START: begin
        state_n = ACK;
        cnt_n   = CNT_W'(1);
      end
      ACK: begin
        if (cpu_bsy) begin
          state_n = RUN;
          cnt_n   = '0;
        end else if (cnt == ACK_LAST) begin
          state_n = FAIL;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!cpu_bsy) state_n = DONE;
        else if (cnt == RUN_LAST) state_n = FAIL;
        else cnt_n = cnt + 1'b1;
      end
      FAIL:   state_n = DONE;
      DONE: begin
        // a fresh accept is newer than anything still pending
        launch = accept || pending;
        if (!accept) begin
          la = pend_a;
          lb = pend_b;
        end
        if (!launch) state_n = IDLE;
      end
    endcase
    if (launch) begin
      state_n = zero_op ? DONE : LOAD;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge CLK_1M or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= 1'b0;
      pend_a       <= '0;
      pend_b       <= '0;
      cpu_wen      <= 1'b0;
      cpu_haddr    <= '0;
      cpu_hdin1    <= '0;
      cpu_hdin2    <= '0;
      cpu_start    <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      run_cycles   <= '0;
      timeout      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cpu_wen   <= (state_n == LOAD);
      cpu_start <= (state_n == START);
      cpu_haddr <= (state_n == LOAD) ? DATA_W'(HADDR_OPS) : '0;
      if (launch) begin
        pending      <= 1'b0;
        busy         <= 1'b1;
        timeout      <= 1'b0;
        result_valid <= 1'b0;
        if (zero_op) begin
          result       <= DATA_W'(la | lb);
          result_valid <= 1'b1;
          run_cycles   <= '0;
        end else begin
          cpu_hdin1 <= DATA_W'(la);
          cpu_hdin2 <= DATA_W'(lb);
        end
      end else if (accept && state != IDLE) begin
        pending <= 1'b1;
        pend_a  <= db_a;
        pend_b  <= db_b;
      end
      // the ACK cycle that saw cpu_bsy rise is counted too
      if (state == RUN && !cpu_bsy) begin
        result       <= cpu_gcd;
        run_cycles   <= cnt + 1'b1;
        result_valid <= 1'b1;
      end
      if (state_n == FAIL)
        timeout <= 1'b1;
      if (state == DONE && !launch)
        busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_run_ctrl.sv
// Scoreboard bench for gcd_run_ctrl with a small CPU model.
// Expected results are queued by the stimulus, checked on busy fall.
module tb_gcd_run_ctrl;

  localparam int OP_W   = 8;
  localparam int DW     = 32;
  localparam int DEB    = 16;
  localparam int SETTLE = 2;
  localparam int ACKTO  = 16;
  localparam int RUNTO  = 1000000;
  localparam int CW     = 24;

  logic          CLK_1M = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    op_a = 8'd12;
  logic [7:0]    op_b = 8'd18;
  logic          cpu_bsy = 1'b0;
  logic [DW-1:0] cpu_gcd = '0;
  logic          cpu_wen, cpu_start, busy;
  logic          result_valid, timeout;
  logic [DW-1:0] cpu_haddr, cpu_hdin1, cpu_hdin2, result;
  logic [CW-1:0] run_cycles;

  gcd_run_ctrl #(
    .OP_W(OP_W), .DATA_W(DW), .DEBOUNCE_CYC(DEB),
    .SETTLE_CYC(SETTLE), .ACK_TO(ACKTO),
    .RUN_TO(RUNTO), .CNT_W(CW)
  ) dut (
    .CLK_1M(CLK_1M), .rst(rst),
    .op_a(op_a), .op_b(op_b),
    .cpu_bsy(cpu_bsy), .cpu_gcd(cpu_gcd),
    .cpu_wen(cpu_wen), .cpu_haddr(cpu_haddr),
    .cpu_hdin1(cpu_hdin1), .cpu_hdin2(cpu_hdin2),
    .cpu_start(cpu_start), .busy(busy),
    .result(result), .result_valid(result_valid),
    .run_cycles(run_cycles), .timeout(timeout)
  );

  always #5 CLK_1M = ~CLK_1M;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic          vld;
    logic          to;
    logic [CW-1:0] rc;
  } exp_t;
  exp_t sb[$];

  task automatic push(int r, bit v, bit t, int c);
    exp_t e;
    e.res = DW'(r);
    e.vld = v;
    e.to  = t;
    e.rc  = CW'(c);
    sb.push_back(e);
  endtask

  // CPU model: busy from the cycle after start for run_len cycles
  int         run_len = 40;
  bit         no_ack = 0;
  bit         arm = 0;
  int         left = 0;
  logic [DW-1:0] ma = '0, mb = '0;

  function automatic logic [DW-1:0] gcd_f(logic [DW-1:0] a, logic [DW-1:0] b);
    logic [DW-1:0] t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  always @(posedge CLK_1M) begin
    #1;
    if (rst) begin
      cpu_bsy = 1'b0;
      left = 0;
      arm = 0;
    end else begin
      if (cpu_wen) begin
        ma = cpu_hdin1;
        mb = cpu_hdin2;
      end
      if (arm) begin
        arm = 0;
        cpu_bsy = 1'b1;
        left = run_len;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          cpu_bsy = 1'b0;
          cpu_gcd = gcd_f(ma, mb);
        end
      end
      if (cpu_start && !no_ack) arm = 1;
    end
  end

  longint cyc = 0;
  always @(posedge CLK_1M) cyc++;

  // monitor
  int     wen_cnt = 0, start_cnt = 0, done_cnt = 0;
  longint wen_cyc = 0, start_cyc = 0, to_cyc = 0;
  logic [DW-1:0] wen_a[$], wen_b[$];
  bit     prev_busy = 0, prev_to = 0;

  always @(negedge CLK_1M) begin
    if (rst) begin
      prev_busy = 0;
      prev_to = 0;
    end else begin
      if (cpu_wen) begin
        wen_cnt++;
        wen_cyc = cyc;
        wen_a.push_back(cpu_hdin1);
        wen_b.push_back(cpu_hdin2);
      end
      if (cpu_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (timeout && !prev_to) to_cyc = cyc;
      if (prev_busy && !busy) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("result_valid", result_valid, e.vld);
          chk("timeout", timeout, e.to);
          chk("run_cycles", run_cycles, e.rc);
        end
      end
      prev_busy = busy;
      prev_to = timeout;
    end
  end

  task automatic tick();
    @(posedge CLK_1M);
    #2;
  endtask

  task automatic wait_done(int target, int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk("completion", done_cnt, target);
  endtask

  task automatic wait_bsy();
    int k = 0;
    while (!cpu_bsy && k < 100) begin
      tick();
      k++;
    end
    chk("bsy_seen", cpu_bsy, 1);
  endtask

  initial begin
    int bw, bs, k;
    bit ok;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_wen", cpu_wen, 0);
    chk("rst_start", cpu_start, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_result", result, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_haddr", cpu_haddr, 0);
    chk("rst_hdin", {cpu_hdin1, cpu_hdin2}, 0);

    // gcd(12,18) with a 40-cycle CPU run
    push(6, 1, 0, 40);
    rst = 1'b0;
    wait_done(1, 200);
    chk("wen_count", wen_cnt, 1);
    chk("hdin1", wen_a[0], 12);
    chk("hdin2", wen_b[0], 18);
    // start is the (2+SETTLE)th sequence cycle, counting LOAD as the first
    chk("start_latency", start_cyc - wen_cyc, 1 + SETTLE);
    chk("start_count", start_cnt, 1);

    // zero operand: no CPU involvement
    bw = wen_cnt;
    bs = start_cnt;
    push(35, 1, 0, 0);
    op_a = 8'd0;
    op_b = 8'd35;
    ok = 0;
    for (k = 0; k < DEB + 4 && !ok; k++) begin
      tick();
      ok = result_valid && result == 35;
    end
    chk("zero_latency", ok, 1);
    wait_done(2, 60);
    chk("zero_no_wen", wen_cnt, bw);
    chk("zero_no_start", start_cnt, bs);

    push(0, 1, 0, 0);
    op_a = 8'd0;
    op_b = 8'd0;
    wait_done(3, 60);

    // CPU never answers
    no_ack = 1;
    push(0, 0, 1, 0);
    op_a = 8'd8;
    op_b = 8'd12;
    wait_done(4, 150);
    chk("ack_timeout_latency", to_cyc - start_cyc, ACKTO);
    no_ack = 0;

    // bouncing switches, then stable 9
    bw = wen_cnt;
    push(3, 1, 0, 40);
    op_a = 8'd9;
    op_b = 8'd3;
    repeat (5) tick();
    op_a = 8'd7;
    repeat (5) tick();
    op_a = 8'd9;
    chk("bounce_no_wen", wen_cnt, bw);
    wait_done(5, 200);
    chk("bounce_one_run", wen_cnt, bw + 1);
    chk("bounce_hdin", {wen_a[bw], wen_b[bw]}, {32'd9, 32'd3});

    // operand change during a run
    bw = wen_cnt;
    push(7, 1, 0, 40);
    op_a = 8'd12;
    op_b = 8'd18;
    wait_bsy();
    repeat (3) tick();
    op_a = 8'd21;
    op_b = 8'd14;
    ok = 0;
    for (k = 0; k < 200 && !ok; k++) begin
      tick();
      ok = result_valid;
    end
    chk("first_run_result", result, 6);
    wait_done(6, 300);
    chk("rerun_wen_count", wen_cnt, bw + 2);
    chk("rerun_hdin", {wen_a[bw + 1], wen_b[bw + 1]}, {32'd21, 32'd14});

    // asynchronous reset in the middle of a run
    op_a = 8'd15;
    op_b = 8'd10;
    wait_bsy();
    repeat (5) tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    chk("arst_flags", {result_valid, timeout, cpu_wen, cpu_start}, 0);
    chk("arst_run_cycles", run_cycles, 0);
    chk("arst_hdin", {cpu_hdin1, cpu_hdin2}, 0);
    repeat (3) tick();
    bs = start_cnt;
    push(5, 1, 0, 40);
    rst = 1'b0;
    repeat (15) tick();
    chk("arst_no_start", start_cnt, bs);
    wait_done(7, 300);
    chk("arst_restart", start_cnt, bs + 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
